// File: rtl/vga_pkg.sv
// Shared timing constants and types for the 640x480@60 VGA scanout path.
package vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

   localparam int IMG_W = 256;
   localparam int IMG_H = 256;
   localparam int X_OFF = 192;
   localparam int Y_OFF = 112;

   localparam int CNT_W = 10;

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [7:0]       pixel_t;
   typedef logic [15:0]      addr_t;

   // Per-pixel control bits that ride the delay line alongside the fetch.
   typedef struct packed {
      logic hsync;
      logic vsync;
      logic blank_n;
      logic in_win;
      logic en_f;
      logic frame_start;
   } ctl_t;

   localparam ctl_t CTL_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank_n: 1'b0,
                                 in_win: 1'b0, en_f: 1'b0, frame_start: 1'b0};

endpackage

// File: rtl/vga_timing_gen.sv
// 800x525 raster counters with raw sync/blank, image-window flag and
// window-relative pixel coordinates.
module vga_timing_gen
   import vga_pkg::*;
(
   input  logic   vga_clk,
   input  logic   reset,
   output cnt_t   h_cnt,
   output cnt_t   v_cnt,
   output logic   hsync_raw,
   output logic   vsync_raw,
   output logic   blank_n_raw,
   output logic   in_win,
   output logic   frame_bound,
   output pixel_t win_x,
   output pixel_t win_y
);

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == cnt_t'(H_TOTAL - 1)) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == cnt_t'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   always_comb begin
      hsync_raw   = !((h_cnt >= cnt_t'(H_SYNC_START)) && (h_cnt <= cnt_t'(H_SYNC_END)));
      vsync_raw   = !((v_cnt >= cnt_t'(V_SYNC_START)) && (v_cnt <= cnt_t'(V_SYNC_END)));
      blank_n_raw = (h_cnt < cnt_t'(H_ACTIVE)) && (v_cnt < cnt_t'(V_ACTIVE));
      in_win      = (h_cnt >= cnt_t'(X_OFF)) && (h_cnt < cnt_t'(X_OFF + IMG_W)) &&
                    (v_cnt >= cnt_t'(Y_OFF)) && (v_cnt < cnt_t'(Y_OFF + IMG_H));
      frame_bound = (h_cnt == '0) && (v_cnt == '0);
      // Window sizes are powers of two, so the low byte of the difference is exact.
      win_x       = h_cnt[7:0] - 8'(X_OFF);
      win_y       = v_cnt[7:0] - 8'(Y_OFF);
   end

endmodule

// File: rtl/vga_frame_scanout.sv
// VGA scanout of a centred 256x256 grayscale window with latency-matched sync.
// Optional macro VGA_SCANOUT_TEST_PATTERN_EN: ramp in the window while disabled.
module vga_frame_scanout
   import vga_pkg::*;
#(
   parameter int RD_LAT = 1
)
(
   input  logic   vga_clk,
   input  logic   reset,
   input  logic   enable,
   output addr_t  pix_addr,
   input  pixel_t pix_data,
   output pixel_t vga_r,
   output pixel_t vga_g,
   output pixel_t vga_b,
   output logic   vga_hsync,
   output logic   vga_vsync,
   output logic   vga_blank_n,
   output logic   vga_sync_n,
   output logic   frame_start
);

   localparam int L = RD_LAT + 2;
   localparam int D = L - 1;

   logic   hsync_raw, vsync_raw, blank_n_raw, in_win, frame_bound;
   pixel_t win_x, win_y;
   cnt_t   h_cnt, v_cnt;

   vga_timing_gen u_timing (
      .vga_clk     (vga_clk),
      .reset       (reset),
      .h_cnt       (h_cnt),
      .v_cnt       (v_cnt),
      .hsync_raw   (hsync_raw),
      .vsync_raw   (vsync_raw),
      .blank_n_raw (blank_n_raw),
      .in_win      (in_win),
      .frame_bound (frame_bound),
      .win_x       (win_x),
      .win_y       (win_y)
   );

   // Synchronizer is left out of reset so a switch held on during reset is
   // already visible at the first frame boundary.
   logic en_meta, en_s, en_f;

   always_ff @(posedge vga_clk) begin
      en_meta <= enable;
      en_s    <= en_meta;
   end

   always_ff @(posedge vga_clk) begin
      if (reset)
         en_f <= 1'b0;
      else if (frame_bound)
         en_f <= en_s;
   end

   // Stage 1: address register
   always_ff @(posedge vga_clk) begin
      if (reset)
         pix_addr <= '0;
      else if (in_win && en_f)
         pix_addr <= {win_y, win_x};
   end

   // Stages 1..L-1: control delay line matching the memory read latency
   ctl_t ctl_now;
   ctl_t ctl_p [D];
   ctl_t ctl_d;

   always_comb begin
      ctl_now = '{hsync: hsync_raw, vsync: vsync_raw, blank_n: blank_n_raw,
                  in_win: in_win, en_f: en_f, frame_start: frame_bound};
      ctl_d   = ctl_p[D-1];
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         for (int i = 0; i < D; i++) ctl_p[i] <= CTL_IDLE;
      end else begin
         ctl_p[0] <= ctl_now;
         for (int i = 1; i < D; i++) ctl_p[i] <= ctl_p[i-1];
      end
   end

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
   pixel_t ramp_p [D];

   always_ff @(posedge vga_clk) begin
      ramp_p[0] <= win_x;
      for (int i = 1; i < D; i++) ramp_p[i] <= ramp_p[i-1];
   end
`endif

   pixel_t gray_nxt, gray_q;

   always_comb begin
      gray_nxt = '0;
      if (ctl_d.blank_n && ctl_d.in_win) begin
         if (ctl_d.en_f)
            gray_nxt = pix_data;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
         else
            gray_nxt = ramp_p[D-1];
`endif
      end
   end

   // Stage L: output register
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         gray_q      <= '0;
         vga_hsync   <= 1'b1;
         vga_vsync   <= 1'b1;
         vga_blank_n <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         gray_q      <= gray_nxt;
         vga_hsync   <= ctl_d.hsync;
         vga_vsync   <= ctl_d.vsync;
         vga_blank_n <= ctl_d.blank_n;
         frame_start <= ctl_d.frame_start;
      end
   end

   assign vga_r      = gray_q;
   assign vga_g      = gray_q;
   assign vga_b      = gray_q;
   assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_frame_scanout.sv
// Directed bench for vga_frame_scanout; frame memory modelled as q = addr[7:0]^addr[15:8].
module tb_vga_frame_scanout;

   localparam int RD_LAT = 1;
   localparam int L      = RD_LAT + 2;
   localparam int F      = 800 * 525;

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
   localparam bit RAMP = 1'b1;
`else
   localparam bit RAMP = 1'b0;
`endif

   logic        vga_clk = 1'b0;
   logic        reset   = 1'b1;
   logic        enable  = 1'b1;
   logic [15:0] pix_addr;
   logic [7:0]  pix_data;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        vga_hsync, vga_vsync, vga_blank_n, vga_sync_n, frame_start;

   int n_checks = 0;
   int n_fail   = 0;
   int idx      = 0;

   always #5 vga_clk = ~vga_clk;

   vga_frame_scanout #(.RD_LAT(RD_LAT)) u_dut (
      .vga_clk     (vga_clk),
      .reset       (reset),
      .enable      (enable),
      .pix_addr    (pix_addr),
      .pix_data    (pix_data),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .vga_hsync   (vga_hsync),
      .vga_vsync   (vga_vsync),
      .vga_blank_n (vga_blank_n),
      .vga_sync_n  (vga_sync_n),
      .frame_start (frame_start)
   );

   logic [7:0] mem_q [RD_LAT];

   always @(posedge vga_clk) begin
      mem_q[0] <= pix_addr[7:0] ^ pix_addr[15:8];
      for (int i = 1; i < RD_LAT; i++) mem_q[i] <= mem_q[i-1];
   end

   assign pix_data = mem_q[RD_LAT-1];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Advance until the counters hold raster index k, then settle 1ns past the edge.
   task automatic goto(input int k);
      if (k > idx) begin
         repeat (k - idx) @(posedge vga_clk);
         idx = k;
         #1;
      end
   endtask

   function automatic int pos(input int h, input int v);
      return v * 800 + h;
   endfunction

   int ka;
   int lows, blanks, first_low;

   initial begin
      repeat (5) @(posedge vga_clk);
      #1;
      check_eq("rst_addr",   pix_addr,    32'h0);
      check_eq("rst_r",      vga_r,       32'h0);
      check_eq("rst_hsync",  vga_hsync,   32'h1);
      check_eq("rst_vsync",  vga_vsync,   32'h1);
      check_eq("rst_blank",  vga_blank_n, 32'h0);
      check_eq("rst_fs",     frame_start, 32'h0);
      check_eq("sync_n",     vga_sync_n,  32'h0);
      reset = 1'b0;
      idx   = 0;

      goto(L - 1); check_eq("fs_early", frame_start, 32'h0);
      goto(L);     check_eq("fs_first", frame_start, 32'h1);
                   check_eq("blank_00", vga_blank_n, 32'h1);
      goto(L + 1); check_eq("fs_pulse", frame_start, 32'h0);

      ka = pos(192, 112);
      goto(ka + 1); check_eq("addr_192_112", pix_addr, 32'h0000);
      goto(ka + 2); check_eq("addr_193_112", pix_addr, 32'h0001);
                    check_eq("rgb_191_112",  vga_r,    32'h00);
                    check_eq("blank_191_112", vga_blank_n, 32'h1);
      goto(ka + 3); check_eq("rgb_192_112",  vga_r,    32'h00);
      goto(ka + 4); check_eq("r_193_112",    vga_r,    32'h01);
                    check_eq("g_193_112",    vga_g,    32'h01);
                    check_eq("b_193_112",    vga_b,    32'h01);

      goto(pos(200, 150) + L); check_eq("rgb_200_150", vga_r, 32'h2E);
      goto(pos(191, 200) + L); check_eq("rgb_191_200", vga_r, 32'h00);
      goto(pos(192, 200) + L); check_eq("rgb_192_200", vga_r, 32'h58);
      goto(pos(447, 200) + L); check_eq("rgb_447_200", vga_r, 32'hA7);
      goto(pos(448, 200) + L); check_eq("rgb_448_200", vga_r, 32'h00);

      lows = 0; blanks = 0; first_low = -1;
      for (int j = 0; j < 800; j++) begin
         goto(pos(j, 210) + L);
         if (vga_hsync == 1'b0) begin
            if (first_low < 0) first_low = j;
            lows++;
         end
         if (vga_blank_n) blanks++;
      end
      check_eq("hsync_low_cnt",   lows,      32'd96);
      check_eq("hsync_low_start", first_low, 32'd656);
      check_eq("blank_line_cnt",  blanks,    32'd640);

      goto(pos(0, 250));
      enable = 1'b0;
      goto(pos(300, 300) + L); check_eq("rgb_300_300_en_off", vga_r, 32'hD0);

      goto(pos(446, 367) + 1); check_eq("addr_446_367", pix_addr, 32'hFFFE);
      goto(pos(447, 367) + 1); check_eq("addr_447_367", pix_addr, 32'hFFFF);
      goto(pos(446, 367) + L); check_eq("rgb_446_367",  vga_r,    32'h01);
      goto(pos(447, 367) + L); check_eq("rgb_447_367",  vga_r,    32'h00);
      goto(pos(300, 368) + 1); check_eq("addr_hold_368", pix_addr, 32'hFFFF);
      goto(pos(300, 368) + L); check_eq("rgb_300_368",  vga_r,    32'h00);
                               check_eq("blank_300_368", vga_blank_n, 32'h1);

      lows = 0; first_low = -1;
      for (int k = pos(0, 480) + L; k < F + L; k++) begin
         goto(k);
         if (vga_vsync == 1'b0) begin
            if (first_low < 0) first_low = k - L;
            lows++;
         end
      end
      check_eq("vsync_low_cnt",   lows,      32'd1600);
      check_eq("vsync_low_start", first_low, pos(0, 490));

      goto(F + L - 1); check_eq("fs2_early", frame_start, 32'h0);
      goto(F + L);     check_eq("fs_period", frame_start, 32'h1);

      goto(F + pos(300, 200) + 1); check_eq("f2_addr_hold", pix_addr, 32'hFFFF);
      goto(F + pos(300, 200) + L); check_eq("f2_rgb_300_200", vga_r, RAMP ? 32'h6C : 32'h00);
                                   check_eq("f2_blank_300_200", vga_blank_n, 32'h1);
      goto(F + pos(447, 200) + L); check_eq("f2_rgb_447_200", vga_r, RAMP ? 32'hFF : 32'h00);
      goto(F + pos(448, 200) + L); check_eq("f2_rgb_448_200", vga_r, 32'h00);
      goto(F + pos(655, 200) + L); check_eq("f2_hsync_655", vga_hsync, 32'h1);
      goto(F + pos(656, 200) + L); check_eq("f2_hsync_656", vga_hsync, 32'h0);

      goto(F + pos(500, 300));
      check_eq("pre_rst_h", u_dut.u_timing.h_cnt, 32'd500);
      reset = 1'b1;
      @(posedge vga_clk);
      #1;
      check_eq("mid_rst_h",     u_dut.u_timing.h_cnt, 32'd0);
      check_eq("mid_rst_v",     u_dut.u_timing.v_cnt, 32'd0);
      check_eq("mid_rst_r",     vga_r,       32'h0);
      check_eq("mid_rst_hsync", vga_hsync,   32'h1);
      check_eq("mid_rst_vsync", vga_vsync,   32'h1);
      check_eq("mid_rst_blank", vga_blank_n, 32'h0);
      check_eq("mid_rst_addr",  pix_addr,    32'h0);
      reset  = 1'b0;
      enable = 1'b1;
      idx    = 0;
      goto(L - 1); check_eq("rst2_fs_early", frame_start, 32'h0);
      goto(L);     check_eq("rst2_fs",       frame_start, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
